// File: rtl/piso_tx_pkg.sv
// piso_tx shared types: FSM state encodings and WIDTH range limits.
// Optional parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Bit position counter for piso_tx: synchronous clear, enable,
// terminal count at LIMIT-1.
module bit_counter #(
   parameter int LIMIT = 8,
   parameter int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
   input  logic          clk,
   input  logic          clear_n,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, with per-bit strobe.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sdata,
   output logic             sstrobe,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_bad
      $error("piso_tx: WIDTH out of range");
   end

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    count;
   logic             tc;
   logic             accept;
   logic             cnt_en;
   logic             go_idle;

`ifdef PISO_TX_PARITY_EN
   logic             par;
`else
   logic             pre_last;
   assign pre_last = (count == CW'(WIDTH - 2));
`endif

   assign accept  = load_valid & load_ready;
   assign cnt_en  = (state == SHIFT) & ~tc;
   // done marks the final bit cycle, so it doubles as the frame-end flag
   assign go_idle = done | (state != SHIFT);

   bit_counter #(
      .LIMIT (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk     (clk),
      .clear_n (clear_n),
      .clr     (accept),
      .en      (cnt_en),
      .count   (count),
      .tc      (tc)
   );

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state      <= IDLE;
         shreg      <= '0;
         sdata      <= 1'b0;
         sstrobe    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
`ifdef PISO_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else if (accept) begin
         state      <= SHIFT;
         shreg      <= din;
         sdata      <= din[0];
         sstrobe    <= 1'b1;
         busy       <= 1'b1;
         done       <= 1'b0;
         load_ready <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par        <= ^din;
`endif
      end else if (go_idle) begin
         state      <= IDLE;
         sdata      <= 1'b0;
         sstrobe    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         shreg <= shreg >> 1;
         sdata <= shreg[1];
`ifdef PISO_TX_PARITY_EN
         if (tc) begin
            state      <= PAR;
            sdata      <= par;
            done       <= 1'b1;
            load_ready <= 1'b1;
         end
`else
         if (pre_last) begin
            done       <= 1'b1;
            load_ready <= 1'b1;
         end
`endif
      end
   end

endmodule
